// File: rtl/reg_file_flags_pkg.sv
// reg_file_flags_pkg
//   Shared definitions for the FASA register file / status block.
//   - REG_ADDR_W, DATA_W : default address and data widths
//   - status_t           : packed ALU flag bundle {zero, parity, odd}
package reg_file_flags_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 8;

  typedef struct packed {
    logic zero;
    logic parity;
    logic odd;
  } status_t;

endpackage

// File: rtl/reg_file_flags_status_reg.sv
// status_reg
//   Latched ALU flags plus the shift-carry flop feeding ALU SC_in.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     flag_we               : load {zero, parity, odd} into the flag bundle
//     zero, parity, odd     : ALU flag values from the current op
//     sc_we, sc_next        : shift-carry load enable and value
//     zero_flag, parity_flag, odd_flag, sc : registered state
//   Reset wins over both enables; otherwise each part holds unless enabled.
module status_reg
  import reg_file_flags_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flag_we,
  input  logic zero,
  input  logic parity,
  input  logic odd,
  input  logic sc_we,
  input  logic sc_next,
  output logic zero_flag,
  output logic parity_flag,
  output logic odd_flag,
  output logic sc
);

  status_t flags;
  logic    sc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
      sc_q  <= 1'b0;
    end else begin
      if (flag_we) flags <= {zero, parity, odd};
      if (sc_we)   sc_q  <= sc_next;
    end
  end

  assign zero_flag   = flags.zero;
  assign parity_flag = flags.parity;
  assign odd_flag    = flags.odd;
  assign sc          = sc_q;

endmodule

// File: rtl/reg_file_flags.sv
// reg_file_flags
//   Architectural register file (2**D x W) plus ALU status/shift-carry
//   registers for the 8-bit FASA datapath.
//   Ports:
//     Clk, Reset                  : clock, synchronous active-high reset
//     RaddrA/RaddrB               : combinational read addresses
//     Waddr, WriteEn, DataIn      : writeback port (1-cycle write latency)
//     FlagWe, ZeroIn/ParityIn/OddIn : flag load
//     ScWe, ScNext                : shift-carry load
//     DataOutA/DataOutB           : read data
//     ZeroFlag/ParityFlag/OddFlag : latched flags
//     ScOut                       : latched shift-carry, to ALU SC_in
//   Build option: define REG_BYPASS_EN to forward DataIn to a read port
//   whose address matches an active write in the same cycle. Without it a
//   read-during-write returns the stored (old) value.
module reg_file_flags
  import reg_file_flags_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int D = REG_ADDR_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [D-1:0] RaddrA,
  input  logic [D-1:0] RaddrB,
  input  logic [D-1:0] Waddr,
  input  logic         WriteEn,
  input  logic [W-1:0] DataIn,
  input  logic         FlagWe,
  input  logic         ZeroIn,
  input  logic         ParityIn,
  input  logic         OddIn,
  input  logic         ScWe,
  input  logic         ScNext,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  output logic         ZeroFlag,
  output logic         ParityFlag,
  output logic         OddFlag,
  output logic         ScOut
);

  localparam int N = 1 << D;

  logic [W-1:0] regs [N];

  // No hardwired zero register: every entry, r0 included, is writable.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (WriteEn) begin
      regs[Waddr] <= DataIn;
    end
  end

`ifdef REG_BYPASS_EN
  // Write-through: forwarding ignores Reset; the write itself is dropped
  // on a reset edge, so the forwarded value only lives for that cycle.
  assign DataOutA = (WriteEn && (RaddrA == Waddr)) ? DataIn : regs[RaddrA];
  assign DataOutB = (WriteEn && (RaddrB == Waddr)) ? DataIn : regs[RaddrB];
`else
  assign DataOutA = regs[RaddrA];
  assign DataOutB = regs[RaddrB];
`endif

  status_reg u_status (
    .clk         (Clk),
    .reset       (Reset),
    .flag_we     (FlagWe),
    .zero        (ZeroIn),
    .parity      (ParityIn),
    .odd         (OddIn),
    .sc_we       (ScWe),
    .sc_next     (ScNext),
    .zero_flag   (ZeroFlag),
    .parity_flag (ParityFlag),
    .odd_flag    (OddFlag),
    .sc          (ScOut)
  );

endmodule

// File: tb/tb_reg_file_flags.sv
// tb_reg_file_flags
//   Table vectors for the directed cases, a hand-written full-file sequence,
//   then random traffic compared with an array-based reference model.
module tb_reg_file_flags;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset, WriteEn, FlagWe, ZeroIn, ParityIn, OddIn, ScWe, ScNext;
  logic [2:0] RaddrA, RaddrB, Waddr;
  logic [7:0] DataIn, DataOutA, DataOutB;
  logic       ZeroFlag, ParityFlag, OddFlag, ScOut;

  always #5 Clk = ~Clk;

  reg_file_flags dut (
    .Clk(Clk), .Reset(Reset), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .Waddr(Waddr), .WriteEn(WriteEn), .DataIn(DataIn), .FlagWe(FlagWe),
    .ZeroIn(ZeroIn), .ParityIn(ParityIn), .OddIn(OddIn), .ScWe(ScWe),
    .ScNext(ScNext), .DataOutA(DataOutA), .DataOutB(DataOutB),
    .ZeroFlag(ZeroFlag), .ParityFlag(ParityFlag), .OddFlag(OddFlag),
    .ScOut(ScOut)
  );

  typedef struct {
    logic       rst, we;
    logic [2:0] wa;
    logic [7:0] din;
    logic [2:0] ra, rb;
    logic       fwe;
    logic [2:0] fin;   // {zero, parity, odd}
    logic       swe, sn;
    logic       chk_rd;
    logic [7:0] ea, eb;  // reads seen before the edge
    logic [2:0] ef;      // flags after the edge
    logic       es;      // ScOut after the edge
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0] m_mem [8];
  logic [2:0] m_fl;
  logic       m_sc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int rst, int we, int wa, int din, int ra, int rb,
                              int fwe, int fin, int swe, int sn,
                              int chk_rd, int ea, int eb, int ef, int es);
    vec_t v;
    v.rst = rst[0]; v.we = we[0]; v.wa = wa[2:0]; v.din = din[7:0];
    v.ra = ra[2:0]; v.rb = rb[2:0]; v.fwe = fwe[0]; v.fin = fin[2:0];
    v.swe = swe[0]; v.sn = sn[0]; v.chk_rd = chk_rd[0];
    v.ea = ea[7:0]; v.eb = eb[7:0]; v.ef = ef[2:0]; v.es = es[0];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] a, input vec_t v);
    if (BYP && v.we && v.wa == a) return v.din;
    return m_mem[a];
  endfunction

  // mode 0: compare with table expectations, 1: with model, 2: drive only
  task automatic apply(input vec_t v, input int mode);
    @(negedge Clk);
    Reset = v.rst; WriteEn = v.we; Waddr = v.wa; DataIn = v.din;
    RaddrA = v.ra; RaddrB = v.rb; FlagWe = v.fwe;
    {ZeroIn, ParityIn, OddIn} = v.fin; ScWe = v.swe; ScNext = v.sn;
    #1;
    if (mode == 0 && v.chk_rd) begin
      chk("tbl_rdA", DataOutA, v.ea);
      chk("tbl_rdB", DataOutB, v.eb);
    end else if (mode == 1) begin
      chk("rnd_rdA", DataOutA, model_read(v.ra, v));
      chk("rnd_rdB", DataOutB, model_read(v.rb, v));
    end
    @(posedge Clk);
    if (v.rst) begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_fl = 3'b000; m_sc = 1'b0;
    end else begin
      if (v.we)  m_mem[v.wa] = v.din;
      if (v.fwe) m_fl = v.fin;
      if (v.swe) m_sc = v.sn;
    end
    #1;
    if (mode == 0) begin
      chk("tbl_flags", {ZeroFlag, ParityFlag, OddFlag}, v.ef);
      chk("tbl_sc", ScOut, v.es);
    end else if (mode == 1) begin
      chk("rnd_flags", {ZeroFlag, ParityFlag, OddFlag}, m_fl);
      chk("rnd_sc", ScOut, m_sc);
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    Reset = 1'b1; WriteEn = 1'b0; Waddr = '0; DataIn = '0; RaddrA = '0;
    RaddrB = '0; FlagWe = 1'b0; ZeroIn = 1'b0; ParityIn = 1'b0;
    OddIn = 1'b0; ScWe = 1'b0; ScNext = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    m_fl = 3'b000; m_sc = 1'b0;

    //            rst we wa din   ra rb fwe fin swe sn chk ea                eb                ef es
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0,                 0,                0, 0));
    tbl.push_back(mk(0, 1, 3, 8'hA5, 3, 3, 0, 0, 0, 0, 1, BYP ? 8'hA5 : 8'h00, BYP ? 8'hA5 : 8'h00, 0, 0));
    // reset beats a write, flag load and sc load in the same cycle
    tbl.push_back(mk(1, 1, 3, 8'h77, 3, 3, 1, 7, 1, 1, 1, BYP ? 8'h77 : 8'hA5, BYP ? 8'h77 : 8'hA5, 0, 0));
    tbl.push_back(mk(0, 1, 5, 8'h3C, 3, 3, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hFF, 5, 5, 0, 0, 0, 0, 1, 8'h3C, 8'h3C, 0, 0));
    tbl.push_back(mk(0, 1, 2, 8'h11, 0, 5, 0, 0, 0, 0, 1, 8'hFF, 8'h3C, 0, 0));
    // read-during-write on both ports
    tbl.push_back(mk(0, 1, 2, 8'h22, 2, 2, 0, 0, 0, 0, 1, BYP ? 8'h22 : 8'h11, BYP ? 8'h22 : 8'h11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 2, 0, 1, 4, 0, 0, 1, 8'h22, 8'hFF, 4, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 2, 2, 0, 3, 0, 0, 1, 8'h22, 8'h22, 4, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 5, 0, 1, 3, 0, 0, 1, 8'h3C, 8'hFF, 3, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 2, 3, 0, 0, 1, 1, 1, 8'h22, 8'h00, 3, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4, 4, 0, 0, 0, 0, 1, 8'h00, 8'h00, 3, 1));
    tbl.push_back(mk(1, 1, 4, 8'h99, 2, 5, 1, 7, 1, 1, 1, 8'h22, 8'h3C, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 2, 4, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 0);

    // full file: consecutive writes with flag/sc enables toggling
    for (int i = 0; i < 8; i++) begin
      v = mk(0, 1, i, 8'h10 + i, 0, 0, i & 1, i, (i >> 1) & 1, i & 1, 0, 0, 0, 0, 0);
      apply(v, 2);
    end
    chk("full_flags", {ZeroFlag, ParityFlag, OddFlag}, 3'b111);
    chk("full_sc", ScOut, 1'b1);
    for (int i = 0; i < 8; i++) begin
      v = mk(0, 0, 0, 0, i, 7 - i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      RaddrA = v.ra; RaddrB = v.rb; WriteEn = 1'b0; FlagWe = 1'b0; ScWe = 1'b0;
      #1;
      chk("full_rdA", DataOutA, 8'h10 + i);
      chk("full_rdB", DataOutB, 8'h17 - i);
    end
    // reset on the cycle of the r7 write discards it
    v = mk(1, 1, 7, 8'h17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(v, 2);
    @(negedge Clk);
    Reset = 1'b0; WriteEn = 1'b0; RaddrA = 3'd7; RaddrB = 3'd0;
    #1;
    chk("rst_r7", DataOutA, 8'h00);
    chk("rst_r0", DataOutB, 8'h00);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      v = mk(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 1), 0, 0, 0, 0, 0);
      // bias toward read-during-write hits
      if ($urandom_range(0, 3) == 0) v.ra = v.wa;
      if ($urandom_range(0, 3) == 0) v.rb = v.wa;
      apply(v, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_flags.md
Name: reg_file_flags

Overview:
- Architectural register file plus status/carry register for the 8-bit FASA datapath.
- Sits on both sides of the ALU:
  - Upstream: the two read ports drive ALU InputA/InputB, and the shift-carry register drives SC_in.
  - Downstream: the write port captures the writeback value (ALU Out or load data), and the flag register latches ALU Zero/Parity/Odd.
- Reads are combinational; all state changes occur on the rising clock edge.

Parameters:
W, 8, data width in bits
D, 3, register address width; the file holds 2**D registers

Ports:
Clk       input   1  system clock; all state updates on rising edge
Reset     input   1  synchronous, active-high reset
RaddrA    input   D  read address, port A (to ALU InputA)
RaddrB    input   D  read address, port B (to ALU InputB)
Waddr     input   D  write address
WriteEn   input   1  register write enable
DataIn    input   W  writeback data
FlagWe    input   1  flag register write enable
ZeroIn    input   1  ALU Zero
ParityIn  input   1  ALU Parity
OddIn     input   1  ALU Odd
ScWe      input   1  shift-carry register write enable
ScNext    input   1  next shift-carry value (controller selects source, e.g. operand MSB)
DataOutA  output  W  contents of register RaddrA
DataOutB  output  W  contents of register RaddrB
ZeroFlag  output  1  latched Zero
ParityFlag output 1  latched Parity
OddFlag   output  1  latched Odd
ScOut     output  1  latched shift-carry, wired to ALU SC_in

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous, active-high.
- Reset:
  - On a rising edge with Reset=1, all 2**D registers clear to 0.
  - ZeroFlag, ParityFlag, OddFlag and ScOut clear to 0.
  - Reset has priority over WriteEn, FlagWe and ScWe in the same cycle.
  - Reset asserted mid-sequence discards any write presented that cycle.
- Reads:
  - DataOutA = reg[RaddrA], DataOutB = reg[RaddrB]; purely combinational, zero latency.
  - A and B may address the same register; both return the same value.
- Writes:
  - On a rising edge with WriteEn=1 and Reset=0, reg[Waddr] <= DataIn.
  - The written value is visible on the read ports from the following cycle (1-cycle write latency).
  - All registers, including reg[0], are writable; there is no hardwired zero.
- Read-during-write (RaddrX == Waddr, WriteEn=1): the read port returns the OLD value that cycle, unless the optional feature is enabled.
- Flags:
  - On an edge with FlagWe=1: {ZeroFlag,ParityFlag,OddFlag} <= {ZeroIn,ParityIn,OddIn}.
  - Otherwise the flags hold. Flags are independent of WriteEn; a compare-style op may set flags without writing a register.
- Shift-carry: on an edge with ScWe=1, ScOut <= ScNext; otherwise it holds. ScOut is registered, so a value written in cycle n feeds SC_in in cycle n+1.
- Simultaneous events: WriteEn, FlagWe and ScWe may all be asserted in one cycle; each updates independently.
- Address width: addresses are exactly D bits, so there is no out-of-range case and the index wraps naturally.
- Latch freedom: there are no latches, and outputs are never X after the first reset edge.

Optional Feature:
- Macro: REG_BYPASS_EN.
- Defined:
  - Write-through forwarding. When WriteEn=1 and RaddrX == Waddr, DataOutX = DataIn combinationally in the same cycle, for both ports independently.
  - During the Reset cycle, reads still forward DataIn if WriteEn=1. This is harmless because the write itself is discarded.
- Undefined: no forwarding; the read-during-write rule returns the old value.
- Storage and flag behaviour are identical in both builds.

Decomposition:
- Shared package definitions gains:
  - REG_ADDR_W (=3) and DATA_W (=8) constants, used as parameter defaults.
  - A packed typedef status_t {zero, parity, odd} for the flag bundle.
- One natural sub-module: status_reg (flag triple + shift-carry flop with enables and sync reset).
- The register array stays in the top module.

Test Plan:
1. Reset check: Reset=1 for one edge after writing 8'hA5 to r3 -> DataOutA(r3)=8'h00; all flags 0; ScOut=0.
2. Write/readback: write 8'h3C to r5 at edge n, RaddrA=5 -> 8'h3C from cycle n+1. Write 8'hFF to r0 -> reads 8'hFF (r0 not hardwired).
3. Read-during-write: r2=8'h11; same cycle WriteEn=1, Waddr=2, DataIn=8'h22, RaddrA=RaddrB=2 -> 8'h11 without REG_BYPASS_EN, 8'h22 with it; both builds read 8'h22 next cycle.
4. Flags and enables:
   - FlagWe=1 with Zero=1, Parity=0, Odd=0 -> flags 1/0/0 next cycle.
   - Then FlagWe=0 with inputs 0/1/1 -> flags stay 1/0/0.
   - WriteEn=0, FlagWe=1 leaves registers unchanged.
5. Shift-carry chain: ScWe=1, ScNext=1 at edge n -> ScOut=1 from n+1. ScWe=0, ScNext=0 -> ScOut holds 1. Reset with ScWe=1, ScNext=1 -> ScOut=0 (reset priority).
6. Simultaneous and full-file:
   - Write r0..r7 with values 8'h10..8'h17 on consecutive edges, with FlagWe and ScWe toggling -> all 8 read back correctly on both ports.
   - Reset asserted on the cycle of the r7 write -> r7 reads 8'h00.
